// File: rtl/conv_result_buffer.sv
// conv_result_buffer: rescales convolution results to OUT_WIDTH with saturation and queues them in a show-ahead circular buffer
module conv_result_buffer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 4,
  parameter int DEPTH     = 16,
  parameter int AW        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AW:0]          level,
  output logic                 full,
  output logic                 overflow,
  output logic                 saturated,
  input  logic                 clr_flags
);
  localparam logic [IN_WIDTH-1:0] MAXV = IN_WIDTH'((1 << OUT_WIDTH) - 1);
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic overflow_q, overflow_d, saturated_q, saturated_d;
  logic [IN_WIDTH-1:0] s;
  logic clip, wr, rd;
  logic [OUT_WIDTH-1:0] stored;
  always_comb begin
    s = in_data >> SHIFT;
    clip = s > MAXV;
    stored = clip ? {OUT_WIDTH{1'b1}} : s[OUT_WIDTH-1:0];
    rd = out_valid & out_ready;
    wr = in_valid & (~full | rd);
    wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d = (wr & ~rd) ? level_q + (AW+1)'(1) : (rd & ~wr) ? level_q - (AW+1)'(1) : level_q;
    overflow_d = (overflow_q & ~clr_flags) | (in_valid & ~wr);
    saturated_d = (saturated_q & ~clr_flags) | (wr & clip);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      overflow_q <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      overflow_q <= overflow_d;
      saturated_q <= saturated_d;
    end
  end
  // Storage is deliberately unreset; level gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= stored;
  end
  assign out_valid = level_q != '0;
  assign out_data = out_valid ? mem[rd_ptr_q] : '0;
  assign level = level_q;
  assign full = level_q == (AW+1)'(DEPTH);
  assign overflow = overflow_q;
  assign saturated = saturated_q;
endmodule

// File: tb/tb_conv_result_buffer.sv
// tb_conv_result_buffer: table vectors, directed corner sequences and random traffic against a queue model
module tb_conv_result_buffer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic in_valid = 1'b0, out_ready = 1'b0, clr_flags = 1'b0;
  logic [7:0] out_data;
  logic out_valid, full, overflow, saturated;
  logic [4:0] level;
  int checks = 0, failures = 0;
  int q[$];
  bit m_ov = 0, m_sat = 0;
  int last_pop;
  typedef struct { logic [15:0] din; logic [7:0] dout; logic sat; } vec_t;
  vec_t vt[8];

  conv_result_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .full(full), .overflow(overflow), .saturated(saturated),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int scale(input int d);
    int s = d / 16;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic check_all();
    chk("level", int'(level), q.size());
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    chk("out_data", int'(out_data), (q.size() != 0) ? q[0] : 0);
    chk("full", int'(full), int'(q.size() == 16));
    chk("overflow", int'(overflow), int'(m_ov));
    chk("saturated", int'(saturated), int'(m_sat));
  endtask

  task automatic step(input bit iv, input int d, input bit ordy, input bit clr);
    bit rd, wr;
    in_valid = iv; in_data = 16'(d); out_ready = ordy; clr_flags = clr;
    @(posedge clk);
    rd = (q.size() != 0) && ordy;
    wr = iv && (q.size() < 16 || rd);
    if (rd) last_pop = q.pop_front();
    m_ov = (m_ov && !clr) || (iv && !wr);
    m_sat = (m_sat && !clr) || (wr && (d / 16) > 255);
    if (wr) q.push_back(scale(d));
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) step(0, 0, 1, 0);
    chk("drain_empty", int'(out_valid), 0);
  endtask

  initial begin
    vt[0] = '{16'h0120, 8'h12, 1'b0};
    vt[1] = '{16'h1230, 8'hFF, 1'b1};
    vt[2] = '{16'h0FF0, 8'hFF, 1'b0};
    vt[3] = '{16'h0FFF, 8'hFF, 1'b0};
    vt[4] = '{16'h1000, 8'hFF, 1'b1};
    vt[5] = '{16'h000F, 8'h00, 1'b0};
    vt[6] = '{16'hFFFF, 8'hFF, 1'b1};
    vt[7] = '{16'h0010, 8'h01, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_saturated", int'(saturated), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      step(0, 0, 0, 1);
      step(1, vt[i].din, 0, 0);
      chk("vec_out", int'(out_data), int'(vt[i].dout));
      chk("vec_sat", int'(saturated), int'(vt[i].sat));
      step(0, 0, 1, 0);
    end
    step(0, 0, 0, 1);
    chk("clr_sat", int'(saturated), 0);

    step(1, 16'h0030, 0, 0);
    chk("lat_valid", int'(out_valid), 1);
    step(1, 16'h0050, 0, 0);
    step(1, 16'h0070, 0, 0);
    chk("lat_level", int'(level), 3);
    drain();

    for (int k = 1; k <= 17; k++) begin
      step(1, k * 16, 0, 0);
      if (k == 16) chk("full_16th", int'(full), 1);
    end
    chk("ovf_17th", int'(overflow), 1);
    chk("ovf_level", int'(level), 16);
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 1, 0);
      chk("drain_order", last_pop, k);
    end

    step(0, 0, 0, 1);
    for (int k = 1; k <= 16; k++) step(1, k * 16, 0, 0);
    step(1, 16'h0AB0, 1, 0);
    chk("simul_level", int'(level), 16);
    chk("simul_ovf", int'(overflow), 0);
    drain();
    chk("simul_last", last_pop, 8'hAB);

    for (int k = 0; k < 40; k++) step(1, (k % 200) * 16, 1, 0);
    drain();

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 16'hFFFF)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);

    for (int k = 0; k < 6; k++) step(1, 16'h0200 + k * 16, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", int'(out_valid), 0);
    chk("async_level", int'(level), 0);
    chk("async_full", int'(full), 0);
    q.delete(); m_ov = 0; m_sat = 0;
    in_valid = 0; out_ready = 0; clr_flags = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(1, 16'h0300 + k * 16, k > 1, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
